// File: rtl/integer_stream_parser.sv
// Streaming signed integer parser: optional sign, decimal digits, saturating result.
// Define INTEGER_STREAM_PARSER_HEX_EN to also accept a "0x"/"0X" radix-16 prefix.
module integer_stream_parser #(
    parameter int VALUE_WIDTH = 32,
    parameter int CHAR_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic [CHAR_WIDTH-1:0]  char_in,
    input  logic                   char_valid,
    output logic                   char_ready,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   done,
    output logic                   overflow,
    output logic                   empty,
    output logic [CHAR_WIDTH-1:0]  term_char
);

    localparam int MW = VALUE_WIDTH + 5;
    localparam logic [VALUE_WIDTH:0] LIM_POS = {2'b00, {(VALUE_WIDTH-1){1'b1}}};
    localparam logic [VALUE_WIDTH:0] LIM_NEG = {2'b01, {(VALUE_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIGNED,
        S_ZERO,
`ifdef INTEGER_STREAM_PARSER_HEX_EN
        S_HEXPFX,
`endif
        S_DIGITS,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   neg_q, neg_d;
    logic [VALUE_WIDTH:0]   mag_q, mag_d;
    logic                   ovf_q, ovf_d;
    logic [VALUE_WIDTH-1:0] value_q;
    logic                   done_q;
    logic                   empty_q;
    logic [CHAR_WIDTH-1:0]  term_q;
    logic                   fin, fin_empty;

    logic [7:0]             c;
    logic                   dec_ok, dig_ok, acc_ovf, xfer;
    logic [3:0]             dig_val;
    logic [4:0]             radix;
    logic [MW-1:0]          acc_full;
    logic [VALUE_WIDTH:0]   lim_mag, acc_mag;

    function automatic logic [VALUE_WIDTH:0] saturate(input logic [MW-1:0] acc,
                                                      input logic [VALUE_WIDTH:0] lim);
        return (acc > MW'(lim)) ? lim : acc[VALUE_WIDTH:0];
    endfunction

    function automatic logic [VALUE_WIDTH-1:0] to_value(input logic neg,
                                                        input logic [VALUE_WIDTH-1:0] m);
        return neg ? (~m + 1'b1) : m;
    endfunction

    assign c          = char_in[7:0];
    assign char_ready = reset_n && enable && (state_q != S_DONE);
    assign xfer       = char_valid && char_ready;
    assign dec_ok     = (c >= 8'h30) && (c <= 8'h39);

`ifdef INTEGER_STREAM_PARSER_HEX_EN
    logic       hex_q, hex_d;
    logic [7:0] lc;
    logic       alpha_ok;

    // Folding bit 5 maps 'A'-'F' onto 'a'-'f'; both have low nibble 1..6.
    assign lc       = c | 8'h20;
    assign alpha_ok = (lc >= 8'h61) && (lc <= 8'h66);
    assign dig_ok   = dec_ok || (hex_q && alpha_ok);
    assign dig_val  = dec_ok ? c[3:0] : (c[3:0] + 4'd9);
    assign radix    = hex_q ? 5'd16 : 5'd10;
`else
    assign dig_ok   = dec_ok;
    assign dig_val  = c[3:0];
    assign radix    = 5'd10;
`endif

    assign acc_full = MW'(mag_q) * MW'(radix) + MW'(dig_val);
    assign lim_mag  = neg_q ? LIM_NEG : LIM_POS;
    assign acc_ovf  = acc_full > MW'(lim_mag);
    assign acc_mag  = saturate(acc_full, lim_mag);

    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        ovf_d     = ovf_q;
        fin       = 1'b0;
        fin_empty = 1'b0;
`ifdef INTEGER_STREAM_PARSER_HEX_EN
        hex_d     = hex_q;
`endif
        case (state_q)
            S_IDLE, S_SIGNED: begin
                if (state_q == S_IDLE && c == 8'h2D) begin
                    neg_d   = 1'b1;
                    state_d = S_SIGNED;
                end else if (state_q == S_IDLE && c == 8'h2B) begin
                    state_d = S_SIGNED;
                end else if (dig_ok) begin
                    mag_d   = acc_mag;
                    state_d = (c == 8'h30) ? S_ZERO : S_DIGITS;
                end else begin
                    fin       = 1'b1;
                    fin_empty = 1'b1;
                end
            end
            S_ZERO: begin
`ifdef INTEGER_STREAM_PARSER_HEX_EN
                if (c == 8'h78 || c == 8'h58) begin
                    hex_d   = 1'b1;
                    state_d = S_HEXPFX;
                end else
`endif
                if (dig_ok) begin
                    mag_d   = acc_mag;
                    state_d = S_DIGITS;
                end else begin
                    fin = 1'b1;
                end
            end
`ifdef INTEGER_STREAM_PARSER_HEX_EN
            S_HEXPFX: begin
                if (dig_ok) begin
                    mag_d   = acc_mag;
                    ovf_d   = ovf_q | acc_ovf;
                    state_d = S_DIGITS;
                end else begin
                    fin       = 1'b1;
                    fin_empty = 1'b1;
                end
            end
`endif
            S_DIGITS: begin
                // Saturated digits are still consumed; only the terminator ends the number.
                if (dig_ok) begin
                    mag_d = acc_mag;
                    ovf_d = ovf_q | acc_ovf;
                end else begin
                    fin = 1'b1;
                end
            end
            default: ;
        endcase
        if (fin) state_d = S_DONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            ovf_q   <= 1'b0;
            value_q <= '0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
            term_q  <= '0;
`ifdef INTEGER_STREAM_PARSER_HEX_EN
            hex_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (enable) begin
                if (start) begin
                    state_q <= S_IDLE;
                    neg_q   <= 1'b0;
                    mag_q   <= '0;
                    ovf_q   <= 1'b0;
                    value_q <= '0;
                    empty_q <= 1'b0;
                    term_q  <= '0;
`ifdef INTEGER_STREAM_PARSER_HEX_EN
                    hex_q   <= 1'b0;
`endif
                end else if (xfer) begin
                    state_q <= state_d;
                    neg_q   <= neg_d;
                    mag_q   <= mag_d;
                    ovf_q   <= ovf_d;
`ifdef INTEGER_STREAM_PARSER_HEX_EN
                    hex_q   <= hex_d;
`endif
                    if (fin) begin
                        value_q <= to_value(neg_q, mag_q[VALUE_WIDTH-1:0]);
                        empty_q <= fin_empty;
                        term_q  <= char_in;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign value     = value_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign empty     = empty_q;
    assign term_char = term_q;

endmodule

// File: doc/integer_stream_parser.md
# integer_stream_parser

Parametrised successor to the hard-wired decimal integer parser in the HTML attribute path. It consumes a character stream through a valid/ready handshake and accepts an optional sign, decimal digits, and an optional hex form. It produces a saturating two's-complement value of configurable width and reports the terminating character. It sits between the tag/attribute tokenizer's char stream and the attribute value registers.

## Interface
- VALUE_WIDTH, 32: width of `value`, two's complement, ≥ 8.
- CHAR_WIDTH, 8: character width; only the low 8 bits are decoded.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset. Single clock domain.
- enable  in  1  level; when low, `char_ready`=0 and all state holds.
- start  in  1  synchronous restart to IDLE; clears `value`, `overflow`, `empty`, `term_char`. Has priority over a char on the same cycle.
- char_in  in  CHAR_WIDTH  current character.
- char_valid  in  1  `char_in` is valid.
- char_ready  out  1  parser accepts `char_in` this cycle.
- value  out  VALUE_WIDTH  parsed result; stable from `done` until the next `start`/reset.
- done  out  1  single-cycle pulse when a number completes.
- overflow  out  1  result was saturated; sticky until `start`.
- empty  out  1  terminated with no digits; `value`=0.
- term_char  out  CHAR_WIDTH  character that ended the number.

## Operation
- Transfer occurs when `char_valid && char_ready`. `char_ready` = `enable && state != DONE`.
- States:
  - IDLE:
    - '-' sets the negative flag and goes to SIGNED.
    - '+' goes to SIGNED.
    - '0' goes to ZERO.
    - '1'–'9' goes to DIGITS.
    - Any other char terminates with `empty`=1.
  - SIGNED:
    - '0' goes to ZERO.
    - '1'–'9' goes to DIGITS.
    - Any other char terminates with `empty`=1.
  - ZERO:
    - 'x'/'X' goes to HEXPFX (HEX_EN only).
    - A digit goes to DIGITS; leading zeros are legal.
    - Any other char terminates with value 0.
  - HEXPFX:
    - A hex digit goes to DIGITS in radix 16.
    - Any other char terminates with `empty`=1.
  - DIGITS: accumulates digits; a non-digit terminates.
  - DONE: holds until `start` or reset.
- A terminator is any non-digit for the current radix, including NUL. It is consumed (handshake completes) and latched into `term_char`.
- Accumulation:
  - The unsigned magnitude register is VALUE_WIDTH+1 bits.
  - Each digit computes `mag*radix + d` at VALUE_WIDTH+5 bits.
  - If the result exceeds the limit, `mag` clamps to the limit and `overflow` is set. Further digits are still consumed until the terminator.
  - Limit is 2^(W-1)-1 when positive and 2^(W-1) when negative.
- On termination, `value` = negative ? −mag : mag, truncated to VALUE_WIDTH bits.
- Hex digits are '0'–'9', 'a'–'f', 'A'–'F'. Case is ignored.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - state=IDLE
  - `value`=0, `done`=0, `overflow`=0, `empty`=0, `term_char`=0, `char_ready`=0 while reset_n is low.
- One char is accepted per cycle, zero bubbles; `char_ready` is combinational from state and `enable`.
- `done` pulses in the cycle after the terminator handshake. `value`, `empty` and `term_char` are valid in that same cycle and are held afterwards.
- Latency for an N-char number plus terminator is N+1 accepted chars plus 1 cycle.
- Back-to-back numbers: `start` may be asserted in the `done` cycle; IDLE and `char_ready`=1 follow on the next cycle.
- `char_valid` low or `enable` low inserts stalls with no state change; the partial magnitude is retained.
- reset_n low mid-number discards everything. No `done` is produced for the aborted number.

## Configuration
- INTEGER_STREAM_PARSER_HEX_EN defined: the "0x"/"0X" prefix selects radix 16, sign allowed ("-0x10" → −16).
- Not defined:
  - HEXPFX does not exist and the radix is fixed at 10.
  - "0x…" terminates at 'x' with value 0, `term_char`='x', `empty`=0.
  - The hex-digit decode logic is removed.

## Test plan
- "1234567\0" continuous valid → `done` once; `value`=1234567; `term_char`=0x00; `overflow`=0; `empty`=0.
- "-42>" with `char_valid` deasserted every other cycle → `value`=0xFFFFFFD6; `term_char`='>'; `done` one cycle after the '>' handshake.
- Boundaries (W=32):
  - "2147483647 " → 0x7FFFFFFF, `overflow`=0.
  - "99999999999 " → 0x7FFFFFFF, `overflow`=1.
  - "-2147483648 " → 0x80000000, `overflow`=0.
  - "-2147483649 " → 0x80000000, `overflow`=1.
- "0x1F " → with HEX_EN `value`=31, `term_char`=' '; without HEX_EN `value`=0, `term_char`='x'.
- "-;" → `empty`=1, `value`=0. "0x\"" (HEX_EN) → `empty`=1.
- reset_n pulsed low after "12" → all outputs 0 immediately. Then `start` + "7 " → `value`=7. `enable` low for 5 cycles mid "345 " → `value`=345.
